// File: rtl/secure_decoder_pkg.sv
// ---------------------------------------------------------------------------
// secure_decoder_pkg
// Constants shared by the security encrypt/decrypt paths.
//   KEY_DEFAULT         : access key expected with every word
//   INV3                : multiplicative inverse of 3 modulo 2^32
//   SUB_K, XOR_K, ADD_K : the same constants the encryptor applies
//   lock_state_t        : states of the key-failure lockout FSM
// ---------------------------------------------------------------------------
package secure_decoder_pkg;

   localparam logic [15:0] KEY_DEFAULT = 16'h0032;
   localparam logic [31:0] INV3        = 32'hAAAAAAAB;
   localparam logic [31:0] SUB_K       = 32'd9;
   localparam logic [31:0] XOR_K       = 32'd2;
   localparam logic [31:0] ADD_K       = 32'd3;

   typedef enum logic [0:0] {
      OPEN   = 1'b0,
      LOCKED = 1'b1
   } lock_state_t;

endpackage

// File: rtl/secure_decoder_lockout.sv
// ---------------------------------------------------------------------------
// secure_decoder_lockout
// Tracks consecutive bad-key words and, once LOCK_LIMIT of them have been
// accepted in a row, holds the decoder input closed for LOCK_CYCLES cycles.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   accept    : a word is accepted this cycle
//   bad_key   : the accepted word carries a wrong key (qualified by accept)
//   locked    : lockout active (high exactly while in LOCKED)
// ---------------------------------------------------------------------------
module secure_decoder_lockout
   import secure_decoder_pkg::*;
#(
   parameter int LOCK_LIMIT  = 3,
   parameter int LOCK_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic accept,
   input  logic bad_key,
   output logic locked
);

   localparam int CNT_BITS = $clog2(LOCK_LIMIT + 1);
   localparam int CNT_W    = (CNT_BITS < 2) ? 2 : CNT_BITS;
   localparam int TMR_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(LOCK_LIMIT - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_CYCLES - 1);

   localparam logic [0:0] S_OPEN   = 1'(OPEN);
   localparam logic [0:0] S_LOCKED = 1'(LOCKED);

   logic [0:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg,   cnt_next;
   logic [TMR_W-1:0] timer_reg, timer_next;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      timer_next = timer_reg;
      case (state_reg)
         S_OPEN: begin
            if (accept) begin
               if (bad_key) begin
                  cnt_next = cnt_reg + CNT_W'(1);
                  // The word that reaches the limit is still accepted;
                  // the input closes from the following cycle.
                  if (cnt_reg == LIMIT_M1) begin
                     state_next = S_LOCKED;
                     timer_next = '0;
                  end
               end else begin
                  cnt_next = '0;
               end
            end
         end
         default: begin
            // Timer runs every cycle, independent of output stalls.
            if (timer_reg == TMR_LAST) begin
               state_next = S_OPEN;
               timer_next = '0;
               cnt_next   = '0;
            end else begin
               timer_next = timer_reg + TMR_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_OPEN;
         cnt_reg   <= '0;
         timer_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         timer_reg <= timer_next;
      end
   end

   assign locked = (state_reg == S_LOCKED);

endmodule

// File: rtl/secure_decoder.sv
// ---------------------------------------------------------------------------
// secure_decoder
// Streaming decryption engine: x = (((y * INV3) - 9) ^ 2) + 3 mod 2^32,
// carried through a 3-stage valid/ready pipeline with a key-failure lockout.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake
//   in_data, in_key      : ciphertext word and the key sampled with it
//   bypass               : pass the word unchanged (sampled with the word)
//   out_valid / out_ready: output handshake
//   out_data, out_err    : plaintext, bad-key flag (out_data = 0 when set)
//   locked               : lockout active
// ---------------------------------------------------------------------------
module secure_decoder
   import secure_decoder_pkg::*;
#(
   parameter int          DATA_W      = 32,
   parameter logic [15:0] KEY         = KEY_DEFAULT,
   parameter int          LOCK_LIMIT  = 3,
   parameter int          LOCK_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [15:0]       in_key,
   input  logic              bypass,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   output logic              locked
);

   localparam logic [DATA_W-1:0] INV3_W  = DATA_W'(INV3);
   localparam logic [DATA_W-1:0] SUB_K_W = DATA_W'(SUB_K);
   localparam logic [DATA_W-1:0] XOR_K_W = DATA_W'(XOR_K);
   localparam logic [DATA_W-1:0] ADD_K_W = DATA_W'(ADD_K);

   logic              s1_valid_reg, s2_valid_reg, s3_valid_reg;
   logic [DATA_W-1:0] s1_data_reg,  s2_data_reg,  out_data_reg;
   logic              s1_bad_reg,   s2_bad_reg,   out_err_reg;
   logic              s1_byp_reg,   s2_byp_reg;

   logic en;
   logic accept;
   logic bad_key;

   // One enable for all stages: the pipe moves whenever the output slot is
   // free or being consumed, so a stall freezes every stage at once.
   assign en       = !s3_valid_reg || out_ready;
   assign in_ready = en && !locked && !rst;
   assign accept   = in_valid && in_ready;
   assign bad_key  = (in_key != KEY);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         s3_valid_reg <= 1'b0;
         s1_data_reg  <= '0;
         s2_data_reg  <= '0;
         out_data_reg <= '0;
         s1_bad_reg   <= 1'b0;
         s2_bad_reg   <= 1'b0;
         out_err_reg  <= 1'b0;
         s1_byp_reg   <= 1'b0;
         s2_byp_reg   <= 1'b0;
      end else if (en) begin
         // Stage 1: multiply by the inverse of 3 (low word kept).
         s1_valid_reg <= accept;
         s1_data_reg  <= bypass ? in_data : in_data * INV3_W;
         s1_bad_reg   <= bad_key;
         s1_byp_reg   <= bypass;

         // Stage 2: subtract and xor; bypassed or rejected words pass as-is.
         s2_valid_reg <= s1_valid_reg;
         s2_data_reg  <= (s1_bad_reg || s1_byp_reg) ? s1_data_reg
                       : ((s1_data_reg - SUB_K_W) ^ XOR_K_W);
         s2_bad_reg   <= s1_bad_reg;
         s2_byp_reg   <= s1_byp_reg;

         // Stage 3: final add; a bad key wins over bypass and zeroes data.
         s3_valid_reg <= s2_valid_reg;
         if (s2_valid_reg) begin
            out_err_reg  <= s2_bad_reg;
            out_data_reg <= s2_bad_reg ? '0
                          : (s2_byp_reg ? s2_data_reg : s2_data_reg + ADD_K_W);
         end
      end
   end

   assign out_valid = s3_valid_reg;
   assign out_data  = out_data_reg;
   assign out_err   = out_err_reg;

   secure_decoder_lockout #(
      .LOCK_LIMIT  (LOCK_LIMIT),
      .LOCK_CYCLES (LOCK_CYCLES)
   ) u_lockout (
      .clk     (clk),
      .rst     (rst),
      .accept  (accept),
      .bad_key (bad_key),
      .locked  (locked)
   );

endmodule

// File: tb/tb_secure_decoder.sv
// ---------------------------------------------------------------------------
// tb_secure_decoder
// Scoreboard bench for secure_decoder. Inputs change on the falling edge;
// the monitor samples 1 time unit later, the driver 2 units later.
// ---------------------------------------------------------------------------
module tb_secure_decoder;

   localparam logic [15:0] GOOD_KEY = 16'h0032;
   localparam logic [15:0] BAD_KEY  = 16'h0031;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [15:0] in_key;
   logic        bypass;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_err;
   logic        locked;

   int vectors     = 0;
   int miscompares = 0;

   logic [32:0] sb[$];          // {err, data}
   logic [32:0] exp_word;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic        prev_err;

   always #5 clk = ~clk;

   secure_decoder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_key    (in_key),
      .bypass    (bypass),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .locked    (locked)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end else begin
         $display("ok   %s: %h", tag, act);
      end
   endtask

   // Forward encryption, used to build ciphertext for known plaintext.
   function automatic logic [31:0] enc(input logic [31:0] x);
      return (((x - 32'd3) ^ 32'd2) + 32'd9) * 32'd3;
   endfunction

   // Present a word from the next falling edge until it is accepted, and
   // push its expected result. in_valid stays high until the next call/idle.
   task automatic put(input logic [31:0] d, input logic [15:0] k,
                      input logic b, input logic [32:0] exp);
      int guard;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_key   = k;
      bypass   = b;
      #2;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         #2;
         guard++;
      end
      if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
      else sb.push_back(exp);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      #2;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 100) begin
         @(negedge clk);
         #2;
         g++;
      end
      check("drain_left", sb.size(), 32'd0);
   endtask

   // Monitor: output stability under stall and scoreboard compare.
   always @(negedge clk) begin
      #1;
      if (rst) begin
         sb.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", out_data, prev_data);
            check("stall_err", 32'(out_err), 32'(prev_err));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_out", out_data, 32'hFFFF_FFFF ^ out_data);
            end else begin
               exp_word = sb.pop_front();
               check("out_data", out_data, exp_word[31:0]);
               check("out_err", 32'(out_err), 32'(exp_word[32]));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_err   = out_err;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      logic flag;
      logic [31:0] x;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = GOOD_KEY;
      bypass = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #2;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Basic decrypt and 3-cycle latency.
      put(32'h1B, GOOD_KEY, 1'b0, {1'b0, 32'h5});
      idle();
      check("lat_c1", 32'(out_valid), 32'd0);
      @(negedge clk); #2;
      check("lat_c2", 32'(out_valid), 32'd0);
      @(negedge clk); #2;
      check("lat_c3", 32'(out_valid), 32'd1);
      drain();

      // Wrap-around, back to back; second result on the very next cycle.
      put(32'h18, GOOD_KEY, 1'b0, {1'b0, 32'h0});
      put(32'h48, GOOD_KEY, 1'b0, {1'b0, 32'h10});
      idle();
      @(negedge clk); #2;
      check("b2b_first", 32'(out_valid), 32'd1);
      @(negedge clk); #2;
      check("b2b_second", 32'(out_valid), 32'd1);
      drain();

      // Backpressure: 4 words, out_ready low for 5 cycles mid-stream.
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               x = $urandom;
               put(enc(x), GOOD_KEY, 1'b0, {1'b0, x});
            end
            idle();
         end
         begin
            repeat (2) @(negedge clk);
            out_ready = 1'b0;
            repeat (5) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();

      // Three bad keys -> lockout for exactly 16 cycles.
      for (int i = 0; i < 3; i++) put(32'h1B + 32'(i), BAD_KEY, 1'b0, {1'b1, 32'h0});
      idle();
      check("lock_rise", 32'(locked), 32'd1);
      check("lock_in_ready", 32'(in_ready), 32'd0);
      n = 0; flag = 1'b0;
      while (locked && n < 40) begin
         n++;
         if (in_ready) flag = 1'b1;
         @(negedge clk); #2;
      end
      check("lock_cycles", 32'(n), 32'd16);
      check("lock_ready_seen", 32'(flag), 32'd0);
      check("unlock_in_ready", 32'(in_ready), 32'd1);
      put(32'h1B, GOOD_KEY, 1'b0, {1'b0, 32'h5});
      idle();
      drain();

      // Counter clear: bad, bad, good, bad never locks.
      put(32'h1, BAD_KEY, 1'b0, {1'b1, 32'h0});
      put(32'h2, BAD_KEY, 1'b0, {1'b1, 32'h0});
      put(32'h1B, GOOD_KEY, 1'b0, {1'b0, 32'h5});
      put(32'h3, BAD_KEY, 1'b0, {1'b1, 32'h0});
      idle();
      flag = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (locked) flag = 1'b1;
         @(negedge clk); #2;
      end
      check("never_locked", 32'(flag), 32'd0);
      drain();

      // Bypass, and bad key taking priority over bypass.
      put(32'hDEADBEEF, GOOD_KEY, 1'b1, {1'b0, 32'hDEADBEEF});
      put(32'hDEADBEEF, BAD_KEY, 1'b1, {1'b1, 32'h0});
      idle();
      drain();

      // Reset with two words in flight: they must never appear.
      put(32'h1B, GOOD_KEY, 1'b0, {1'b0, 32'h5});
      put(32'h48, GOOD_KEY, 1'b0, {1'b0, 32'h10});
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #2;
      check("rst_mid_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk); #2;
      check("rst_mid_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #2;
      flag = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) flag = 1'b1;
         @(negedge clk); #2;
      end
      check("flushed_words", 32'(flag), 32'd0);
      check("rst_mid_locked", 32'(locked), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
